// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared types and field positions for the wave generator run sequencer
//
// Holds the per-channel sequencer state encoding, the run-word bit positions
// and the half-word field positions used to split the A/B register words.
package wavegen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int RUN_A_BIT = 0;
    localparam int RUN_B_BIT = 1;

    localparam int HALF_W    = 16;
    localparam int CH_A_LSB  = 0;
    localparam int CH_B_LSB  = 16;

endpackage

// File: rtl/wavegen_chan_seq.sv
// rtl/wavegen_chan_seq.sv - one channel's run FSM, period counter and shadow registers
//
// Configuration macro: WAVEGEN_CYCLE_CNT_EN
//   defined   : period counting, DONE state, done/rem outputs active
//   undefined : cycles ignored, channel runs continuously, done/rem tied to 0
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             channel run bit
//   cycles          programmed period count (0 = continuous)
//   frq/ofst/ampl/dcyc   live register fields for this channel
//   wrap            one-cycle phase-wrap pulse from the datapath
//   en, clr, done   accumulator enable, phase-clear pulse, finished flag
//   rem             periods remaining
//   frq_s/ofst_s/ampl_s/dcyc_s   shadowed fields seen by the datapath
module wavegen_chan_seq
    import wavegen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [CNT_W-1:0]    cycles,
    input  logic [31:0]         frq,
    input  logic [HALF_W-1:0]   ofst,
    input  logic [HALF_W-1:0]   ampl,
    input  logic [HALF_W-1:0]   dcyc,
    input  logic                wrap,
    output logic                en,
    output logic                clr,
    output logic                done,
    output logic [CNT_W-1:0]    rem,
    output logic [31:0]         frq_s,
    output logic [HALF_W-1:0]   ofst_s,
    output logic [HALF_W-1:0]   ampl_s,
    output logic [HALF_W-1:0]   dcyc_s
);

    seq_state_e          state_q, state_d;
    logic [31:0]         frq_q, frq_d;
    logic [HALF_W-1:0]   ofst_q, ofst_d;
    logic [HALF_W-1:0]   ampl_q, ampl_d;
    logic [HALF_W-1:0]   dcyc_q, dcyc_d;

`ifdef WAVEGEN_CYCLE_CNT_EN
    logic [CNT_W-1:0]    rem_q, rem_d;
`else
    logic                unused_cycles;
    assign unused_cycles = ^cycles;
`endif

    always_comb begin
        state_d = state_q;
        frq_d   = frq_q;
        ofst_d  = ofst_q;
        ampl_d  = ampl_q;
        dcyc_d  = dcyc_q;
`ifdef WAVEGEN_CYCLE_CNT_EN
        rem_d   = rem_q;
`endif
        // A low run bit wins over everything, including a wrap in the same cycle.
        if (!run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = START;
                START: begin
                    state_d = RUN;
                    frq_d   = frq;
                    ofst_d  = ofst;
                    ampl_d  = ampl;
                    dcyc_d  = dcyc;
`ifdef WAVEGEN_CYCLE_CNT_EN
                    rem_d   = cycles;
`endif
                end
                RUN: begin
                    if (wrap) begin
`ifdef WAVEGEN_CYCLE_CNT_EN
                        if (rem_q == CNT_W'(1)) begin
                            // Final period: no shadow reload, the channel stops here.
                            state_d = DONE;
                            rem_d   = '0;
                        end else begin
                            if (rem_q != '0) begin
                                rem_d = rem_q - CNT_W'(1);
                            end
                            frq_d  = frq;
                            ofst_d = ofst;
                            ampl_d = ampl;
                            dcyc_d = dcyc;
                        end
`else
                        frq_d  = frq;
                        ofst_d = ofst;
                        ampl_d = ampl;
                        dcyc_d = dcyc;
`endif
                    end
                end
                // DONE holds until run drops; there is no auto-restart.
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            frq_q   <= '0;
            ofst_q  <= '0;
            ampl_q  <= '0;
            dcyc_q  <= '0;
`ifdef WAVEGEN_CYCLE_CNT_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            frq_q   <= frq_d;
            ofst_q  <= ofst_d;
            ampl_q  <= ampl_d;
            dcyc_q  <= dcyc_d;
`ifdef WAVEGEN_CYCLE_CNT_EN
            rem_q   <= rem_d;
`endif
        end
    end

    // Control outputs are Moore-decoded from the registered state.
    assign en     = (state_q == RUN);
    assign clr    = (state_q == START);
    assign frq_s  = frq_q;
    assign ofst_s = ofst_q;
    assign ampl_s = ampl_q;
    assign dcyc_s = dcyc_q;

`ifdef WAVEGEN_CYCLE_CNT_EN
    assign done = (state_q == DONE);
    assign rem  = rem_q;
`else
    assign done = 1'b0;
    assign rem  = '0;
`endif

endmodule

// File: rtl/wavegen_seq_ctrl.sv
// rtl/wavegen_seq_ctrl.sv - two-channel run sequencer between register block and DDS datapath
//
// Configuration macro: WAVEGEN_CYCLE_CNT_EN (see wavegen_chan_seq).
// CNT_W must be <= 16: each channel owns one half of the cycles word.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET      clock, asynchronous active-high reset
//   runn_W_I                      bit0 runs A, bit1 runs B
//   cycl_W_I                      [15:0] A count, [31:16] B count
//   frqA_W_I, frqB_W_I            live phase increments
//   ofst_W_I, ampl_W_I, dCyc_W_I  live A/B half-word fields
//   wrap_A_I, wrap_B_I            phase-wrap pulses
//   en_*_O, clr_*_O               accumulator enable, phase-clear pulse
//   frq*_S_O, ofst/ampl/dCyc_S_O  shadowed parameters
//   done_O                        bit0 A finished, bit1 B finished
//   remA_O, remB_O                periods remaining
module wavegen_seq_ctrl
    import wavegen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic [31:0]        runn_W_I,
    input  logic [31:0]        cycl_W_I,
    input  logic [31:0]        frqA_W_I,
    input  logic [31:0]        frqB_W_I,
    input  logic [31:0]        ofst_W_I,
    input  logic [31:0]        ampl_W_I,
    input  logic [31:0]        dCyc_W_I,
    input  logic               wrap_A_I,
    input  logic               wrap_B_I,
    output logic               en_A_O,
    output logic               en_B_O,
    output logic               clr_A_O,
    output logic               clr_B_O,
    output logic [31:0]        frqA_S_O,
    output logic [31:0]        frqB_S_O,
    output logic [31:0]        ofst_S_O,
    output logic [31:0]        ampl_S_O,
    output logic [31:0]        dCyc_S_O,
    output logic [1:0]         done_O,
    output logic [CNT_W-1:0]   remA_O,
    output logic [CNT_W-1:0]   remB_O
);

    // Upper run bits and any cycle-count bits above CNT_W carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{runn_W_I, cycl_W_I};

    logic done_a, done_b;

    wavegen_chan_seq #(.CNT_W(CNT_W)) u_chan_a (
        .clk    (S_AXI_ACLK),
        .rst    (S_AXI_ARESET),
        .run    (runn_W_I[RUN_A_BIT]),
        .cycles (cycl_W_I[CH_A_LSB +: CNT_W]),
        .frq    (frqA_W_I),
        .ofst   (ofst_W_I[CH_A_LSB +: HALF_W]),
        .ampl   (ampl_W_I[CH_A_LSB +: HALF_W]),
        .dcyc   (dCyc_W_I[CH_A_LSB +: HALF_W]),
        .wrap   (wrap_A_I),
        .en     (en_A_O),
        .clr    (clr_A_O),
        .done   (done_a),
        .rem    (remA_O),
        .frq_s  (frqA_S_O),
        .ofst_s (ofst_S_O[CH_A_LSB +: HALF_W]),
        .ampl_s (ampl_S_O[CH_A_LSB +: HALF_W]),
        .dcyc_s (dCyc_S_O[CH_A_LSB +: HALF_W])
    );

    wavegen_chan_seq #(.CNT_W(CNT_W)) u_chan_b (
        .clk    (S_AXI_ACLK),
        .rst    (S_AXI_ARESET),
        .run    (runn_W_I[RUN_B_BIT]),
        .cycles (cycl_W_I[CH_B_LSB +: CNT_W]),
        .frq    (frqB_W_I),
        .ofst   (ofst_W_I[CH_B_LSB +: HALF_W]),
        .ampl   (ampl_W_I[CH_B_LSB +: HALF_W]),
        .dcyc   (dCyc_W_I[CH_B_LSB +: HALF_W]),
        .wrap   (wrap_B_I),
        .en     (en_B_O),
        .clr    (clr_B_O),
        .done   (done_b),
        .rem    (remB_O),
        .frq_s  (frqB_S_O),
        .ofst_s (ofst_S_O[CH_B_LSB +: HALF_W]),
        .ampl_s (ampl_S_O[CH_B_LSB +: HALF_W]),
        .dcyc_s (dCyc_S_O[CH_B_LSB +: HALF_W])
    );

    assign done_O = {done_b, done_a};

endmodule

// File: doc/wavegen_seq_ctrl.md
# wavegen_seq_ctrl

Run sequencer for the two-channel wave generator. It sits between the AXI register block's decoded outputs (run, cycles, frequency, offset, amplitude, duty cycle) and the per-channel phase-accumulator/DDS datapath. It starts and stops each channel, clears its phase on start, counts completed waveform periods against a programmed cycle count, and holds shadow copies of the waveform parameters so that register writes take effect only at period boundaries.

## Interface
Parameters:
- CNT_W, default 16: per-channel cycle-counter width. It must be ≤ 16, because each channel owns one half of the cycles word.

Ports:
- S_AXI_ACLK  in  1  single clock for the block.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- runn_W_I  in  32  run word: bit0 runs channel A, bit1 runs channel B, other bits ignored.
- cycl_W_I  in  32  cycle counts: [15:0] for A, [31:16] for B. A count of 0 means continuous.
- frqA_W_I, frqB_W_I  in  32  per-channel phase increments.
- ofst_W_I, ampl_W_I, dCyc_W_I  in  32  each word is split [15:0] for A and [31:16] for B.
- wrap_A_I, wrap_B_I  in  1  one-cycle pulse from the datapath when the channel's phase wraps.
- en_A_O, en_B_O  out  1  accumulator enable.
- clr_A_O, clr_B_O  out  1  phase clear, a one-cycle pulse.
- frqA_S_O, frqB_S_O  out  32  shadowed frequency.
- ofst_S_O, ampl_S_O, dCyc_S_O  out  32  shadowed words with the same A/B halves.
- done_O  out  2  bit0 = A finished, bit1 = B finished.
- remA_O, remB_O  out  CNT_W  periods remaining.

## Operation
- Each channel runs an independent FSM with states IDLE, START, RUN and DONE.
  - **IDLE**: if the run bit = 1, go to START.
  - **START** (exactly one cycle): clr = 1, load that channel's shadow fields, load rem ← cycles[CNT_W-1:0], then go to RUN.
  - **RUN**: en = 1.
    - On wrap with rem == 1 (counting enabled), go to DONE and set rem ← 0.
    - On wrap otherwise, decrement rem when it is non-zero and reload the channel's shadow fields.
    - rem == 0 at entry means continuous: there is no decrement and DONE is never reached.
  - **DONE**: en = 0 and done = 1. The channel stays in DONE until the run bit = 0, then goes to IDLE. There is no auto-restart.
- A run bit of 0 in any state sends the channel to IDLE on the next edge. This takes priority over a simultaneous wrap.
- wrap is ignored outside RUN.
- Shadow fields change only in START or on a non-final RUN wrap. Register writes at any other time are invisible to the datapath.
- Channels A and B are fully independent. Simultaneous events on both channels are processed in the same cycle.

## Timing
- Reset (asynchronous): both FSMs go to IDLE. en, clr, done, rem and all shadow outputs are 0.
- All outputs are registered or Moore-decoded from state. There is no combinational input-to-output path.
- Start latency:
  - The run bit is sampled high at edge k.
  - clr is high from edge k to edge k+1.
  - en is high from edge k+1.
- Stop latency: the run bit is sampled low at edge k, and en is low from edge k.
- Completion: the final wrap is sampled at edge k. From edge k, en = 0 and done = 1.
- Reset asserted mid-RUN forces the reset values immediately. Operation resumes through IDLE → START.

## Configuration
- Macro WAVEGEN_CYCLE_CNT_EN.
- **Defined**: cycle counting, the DONE state, done_O and remA_O/remB_O behave as above.
- **Undefined**: the cycles input is ignored and every channel runs continuously. The FSM never enters DONE. done_O, remA_O and remB_O are tied to 0. Shadow reload on wrap is retained.

## Structure
- **wavegen_pkg** holds the state typedef (IDLE/START/RUN/DONE), run-bit positions (RUN_A_BIT = 0, RUN_B_BIT = 1) and half-word field localparams (CH_A_LSB = 0, CH_B_LSB = 16).
- **wavegen_chan_seq** is one sub-module holding a single channel's FSM, rem counter and shadow registers. It is instantiated twice, with the A/B half-words muxed at the top level.

## Test plan
- Reset with all inputs at 0, then hold run = 0 for 10 cycles → all outputs 0. Assert reset mid-RUN → en_A_O drops asynchronously.
- cycl = 0x0000_0003, run = 0x1, three wrap_A pulses → clr_A for 1 cycle, en_A high 2 edges after the run edge, remA steps 3→2→1→0, then done_O = 01 and en_A = 0.
- cycl = 0, run = 0x3 with 100 wrap pulses per channel → both en stay high, done_O = 00, remA_O/remB_O = 0.
- Write frqA 0x100 → 0x200 mid-period → frqA_S_O changes only in the cycle after the next wrap_A.
- run cleared in the same cycle as the final wrap → FSM goes to IDLE, done_O = 00. With run held at 1 in DONE, no restart until run toggles 0→1.
- Undefine WAVEGEN_CYCLE_CNT_EN with cycl = 2 and 5 wraps → en stays high and done_O = 00.
